// File: rtl/pwm_duty_sequencer_if.sv
// Host register-write channel for pwm_duty_sequencer.
// The host drives valid/addr/data; the sequencer answers with ready.
interface pwm_duty_sequencer_if;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty cycle toward a target in prescaled steps, committing each step at a PWM period boundary.
// Optional feature macro: PWM_SEQ_BOUNCE_EN (ping-pong between start value and target until aborted).
module pwm_duty_sequencer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_sequencer_if.slave  wr,
    input  logic                 period_end,
    output logic [7:0]           duty_out,
    output logic                 duty_update,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DUTY_W = 8;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] A_TARGET  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STEP    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PRE_LO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PRE_HI  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_DUTY    = ADDR_W'(5);

    localparam logic [DIV_W-1:0] PRE_LO_MASK = DIV_W'(8'hFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [DUTY_W-1:0]   duty_n;
    logic                duty_update_n;
    logic                busy_n;
    logic                done_n;
    logic [DUTY_W-1:0]   target, target_n;
    logic [DUTY_W-1:0]   step, step_n;
    logic [DIV_W-1:0]    prescale, prescale_n;
    logic                bounce, bounce_n;
    logic [DUTY_W-1:0]   start_val, start_val_n;
    logic [DUTY_W-1:0]   pend, pend_n;
    logic [DIV_W-1:0]    cnt, cnt_n;

    logic                wr_fire;
    logic                ctrl_wr;
    logic                start_req;
    logic                abort_req;
    logic                bounce_req;
    logic [DUTY_W-1:0]   step_eff;
    logic [DUTY_W-1:0]   ramp_val;

    // Only ctrl (abort) writes may land while a ramp is in flight.
    always_comb begin
        wr.wr_ready = (state == IDLE) || (wr.wr_addr == A_CTRL);
    end

    always_comb begin
        wr_fire   = wr.wr_valid && wr.wr_ready;
        ctrl_wr   = wr_fire && (wr.wr_addr == A_CTRL);
        abort_req = ctrl_wr && wr.wr_data[1];
        start_req = ctrl_wr && wr.wr_data[0] && !wr.wr_data[1];
`ifdef PWM_SEQ_BOUNCE_EN
        bounce_req = wr.wr_data[2];
`else
        bounce_req = 1'b0;
`endif
    end

    // One step toward target, clamped at target so the 8-bit value never overshoots or wraps.
    always_comb begin
        step_eff = (step == '0) ? DUTY_W'(1) : step;
        ramp_val = duty_out;
        if (target >= duty_out) begin
            if ((target - duty_out) <= step_eff) ramp_val = target;
            else                                 ramp_val = duty_out + step_eff;
        end else begin
            if ((duty_out - target) <= step_eff) ramp_val = target;
            else                                 ramp_val = duty_out - step_eff;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        duty_n        = duty_out;
        duty_update_n = 1'b0;
        done_n        = 1'b0;
        target_n      = target;
        step_n        = step;
        prescale_n    = prescale;
        bounce_n      = bounce;
        start_val_n   = start_val;
        pend_n        = pend;
        cnt_n         = cnt;

        unique case (state)
            IDLE: begin
                if (wr_fire) begin
                    unique case (wr.wr_addr)
                        A_TARGET: target_n = wr.wr_data;
                        A_STEP:   step_n   = wr.wr_data;
                        A_PRE_LO: prescale_n = (prescale & ~PRE_LO_MASK) | DIV_W'(wr.wr_data);
                        A_PRE_HI: prescale_n = (prescale & PRE_LO_MASK) | DIV_W'({wr.wr_data, 8'h00});
                        A_CTRL: begin
                            if (start_req) begin
                                start_val_n = duty_out;
                                cnt_n       = '0;
                                bounce_n    = bounce_req;
                                state_n     = RAMP;
                            end
                        end
                        A_DUTY: begin
                            duty_n        = wr.wr_data;
                            duty_update_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            RAMP: begin
                if (abort_req) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (duty_out == target) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt == prescale) begin
                    cnt_n   = '0;
                    pend_n  = ramp_val;
                    state_n = APPLY;
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end

            APPLY: begin
                if (abort_req) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (period_end) begin
                    duty_n        = pend;
                    duty_update_n = 1'b1;
                    cnt_n         = '0;
                    if (pend == target) begin
                        done_n = 1'b1;
                        if (bounce) begin
                            target_n    = start_val;
                            start_val_n = target;
                            state_n     = RAMP;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = RAMP;
                    end
                end
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            duty_out    <= '0;
            duty_update <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            target      <= '0;
            step        <= DUTY_W'(1);
            prescale    <= '0;
            bounce      <= 1'b0;
            start_val   <= '0;
            pend        <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            duty_out    <= duty_n;
            duty_update <= duty_update_n;
            busy        <= busy_n;
            done        <= done_n;
            target      <= target_n;
            step        <= step_n;
            prescale    <= prescale_n;
            bounce      <= bounce_n;
            start_val   <= start_val_n;
            pend        <= pend_n;
            cnt         <= cnt_n;
        end
    end

endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, prescaler width in bits.
REQ-002 SHALL have clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have wr_valid, input, 1, host register write request.
REQ-005 SHALL have wr_addr, input, 3, register address.
REQ-006 SHALL have wr_data, input, 8, write data.
REQ-007 SHALL have wr_ready, output, 1, write accepted when wr_valid && wr_ready.
REQ-008 SHALL have period_end, input, 1, one-cycle pulse from the PWM datapath at each PWM period boundary.
REQ-009 SHALL have duty_out, output, 8, duty cycle driven to the PWM datapath.
REQ-010 SHALL have duty_update, output, 1, one-cycle pulse in the cycle duty_out takes a new value.
REQ-011 SHALL have busy, output, 1, high while state is not IDLE.
REQ-012 SHALL have done, output, 1, one-cycle pulse when a ramp completes or is aborted.

Function
REQ-013 SHALL map registers: 0 target; 1 step; 2 prescale[7:0]; 3 prescale[DIV_W-1:8]; 4 ctrl (bit0 start, bit1 abort, bit2 bounce); 5 direct duty; 6-7 ignored but accepted.
REQ-014 SHALL drive wr_ready combinationally: 1 in IDLE; in RAMP/APPLY, 1 only when wr_addr==4.
REQ-015 SHALL implement states IDLE, RAMP, APPLY.
REQ-016 IDLE: accepted ctrl write with start=1 SHALL capture start_val=duty_out, clear prescaler, enter RAMP next cycle.
REQ-017 IDLE: accepted write to addr 5 SHALL load duty_out next cycle with a duty_update pulse in that same cycle.
REQ-018 RAMP: prescaler SHALL count clk cycles 0..prescale; a tick occurs at count==prescale, then counter returns to 0; prescale 0 ticks every cycle.
REQ-019 On tick SHALL compute next = duty_out moved toward target by step, saturating at target (no overshoot, no 8-bit wrap); step 0 SHALL be treated as 1; then enter APPLY.
REQ-020 APPLY: on period_end SHALL commit next to duty_out and pulse duty_update same cycle; duty_out SHALL never change outside period_end in RAMP/APPLY.
REQ-021 After commit, if duty_out==target SHALL pulse done and return to IDLE (unless bounce, REQ-027); otherwise return to RAMP with prescaler cleared.
REQ-022 Start with target==duty_out SHALL pulse done one cycle after entering RAMP, no duty_update.
REQ-023 Accepted abort in RAMP/APPLY SHALL return to IDLE next cycle, discard pending value, hold duty_out, pulse done; abort wins over simultaneous tick or period_end.
REQ-024 Start and abort set in one write SHALL be treated as abort (no-op in IDLE, no done pulse in IDLE).
REQ-025 Writes not accepted (wr_ready=0) SHALL have no effect.

Reset
REQ-026 On rst SHALL set state IDLE, duty_out 0, target 0, step 1, prescale 0, bounce 0, prescaler 0, duty_update 0, busy 0, done 0; rst mid-ramp SHALL abandon the ramp with no done pulse.

Configuration
REQ-027 With PWM_SEQ_BOUNCE_EN defined and ctrl bit2 set at start: on reaching target SHALL swap target and start_val, pulse done, and continue in RAMP until aborted.
REQ-028 Without PWM_SEQ_BOUNCE_EN, ctrl bit2 SHALL be ignored and every ramp SHALL end in IDLE.

Verification
REQ-029 Reset, then write addr5=0x80 -> duty_out=0x80 next cycle with one duty_update pulse, busy=0.
REQ-030 target=0x40, step=0x10, prescale=3, start from 0x00, period_end every 8 cycles -> duty_out 0x10,0x20,0x30,0x40 each at a period_end, then one done pulse, busy=0.
REQ-031 duty_out=0xF8, target=0xFF, step=0x10, start -> single update to 0xFF (no wrap to 0x08), done.
REQ-032 Abort written in same cycle as period_end during APPLY -> duty_out unchanged, no duty_update, done pulse, IDLE; writes to addr 0 during busy see wr_ready=0 and target unchanged.
REQ-033 rst asserted mid-ramp at duty_out=0x20 -> all outputs at reset values next cycle, no done pulse.
REQ-034 With PWM_SEQ_BOUNCE_EN: start 0x00, target 0x20, step 0x10, bounce=1 -> 0x10,0x20,(done),0x10,0x00,(done),0x10... until abort.
